// File: rtl/fisc_ex_pkg.sv
// rtl/fisc_ex_pkg.sv - FISC execute-stage shared types: condition codes, NZCV flags, EX/MEM payload.
package fisc_ex_pkg;

  localparam int FISC_INTEGER_SZ = 64;
  localparam int FISC_REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic [FISC_INTEGER_SZ-1:0] y;
    logic [FISC_REG_ADDR_W-1:0] rd;
    logic                       wr_en;
    logic                       mem_rd;
    logic                       mem_wr;
    logic [FISC_INTEGER_SZ-1:0] store_data;
    logic [FISC_INTEGER_SZ-1:0] br_target;
    logic                       br_taken;
  } ex_mem_payload_t;

endpackage

// File: rtl/fisc_cond_eval.sv
// rtl/fisc_cond_eval.sv - combinational ARM condition-code evaluator (B.cond, CSEL/CSINC).
module fisc_cond_eval
  import fisc_ex_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       taken_o
);

  nzcv_t f;
  assign f = nzcv_t'(nzcv_i);

  always_comb begin
    taken_o = 1'b1;
    case (cond_e'(cond_i))
      COND_EQ: taken_o = f.z;
      COND_NE: taken_o = !f.z;
      COND_HS: taken_o = f.c;
      COND_LO: taken_o = !f.c;
      COND_MI: taken_o = f.n;
      COND_PL: taken_o = !f.n;
      COND_VS: taken_o = f.v;
      COND_VC: taken_o = !f.v;
      COND_HI: taken_o = f.c && !f.z;
      COND_LS: taken_o = !f.c || f.z;
      COND_GE: taken_o = (f.n == f.v);
      COND_LT: taken_o = (f.n != f.v);
      COND_GT: taken_o = !f.z && (f.n == f.v);
      COND_LE: taken_o = f.z || (f.n != f.v);
      default: taken_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/fisc_ex_mem_stage.sv
// rtl/fisc_ex_mem_stage.sv - EX->MEM pipeline register with NZCV flags and B.cond resolution.
// FISC_EXMEM_SKID_EN selects the 2-entry (registered in_ready) variant.
module fisc_ex_mem_stage
  import fisc_ex_pkg::*;
#(
  parameter int DATA_W     = FISC_INTEGER_SZ,
  parameter int REG_ADDR_W = FISC_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_y,
  input  logic                  in_flag_n,
  input  logic                  in_flag_z,
  input  logic                  in_flag_v,
  input  logic                  in_flag_c,
  input  logic                  in_set_flags,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wr_en,
  input  logic                  in_mem_rd,
  input  logic                  in_mem_wr,
  input  logic [DATA_W-1:0]     in_store_data,
  input  logic                  in_is_bcond,
  input  logic [3:0]            in_cond,
  input  logic [DATA_W-1:0]     in_br_target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_y,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wr_en,
  output logic                  out_mem_rd,
  output logic                  out_mem_wr,
  output logic [DATA_W-1:0]     out_store_data,
  output logic [DATA_W-1:0]     out_br_target,
  output logic                  out_br_taken,
  output logic [3:0]            nzcv_q
);

  ex_mem_payload_t in_pl, main_q, main_d;
  logic            main_valid_q, main_valid_d;
  nzcv_t           flags_q, flags_d;
  logic            cond_true, accept;

  // Evaluated against the flags held before this beat's own update.
  fisc_cond_eval u_cond (
    .cond_i  (in_cond),
    .nzcv_i  (flags_q),
    .taken_o (cond_true)
  );

  assign accept = in_valid && in_ready && !flush;

  always_comb begin
    in_pl            = '0;
    in_pl.y          = in_y;
    in_pl.rd         = in_rd;
    in_pl.wr_en      = in_wr_en;
    in_pl.mem_rd     = in_mem_rd;
    in_pl.mem_wr     = in_mem_wr;
    in_pl.store_data = in_store_data;
    in_pl.br_target  = in_br_target;
    in_pl.br_taken   = in_is_bcond && cond_true;
  end

  always_comb begin
    flags_d = flags_q;
    if (accept && in_set_flags) flags_d = '{n: in_flag_n, z: in_flag_z, c: in_flag_c, v: in_flag_v};
  end

`ifdef FISC_EXMEM_SKID_EN
  ex_mem_payload_t skid_q, skid_d;
  logic            skid_valid_q, skid_valid_d;

  assign in_ready = !skid_valid_q;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (out_ready) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || out_ready) begin
        main_d       = in_pl;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_pl;
        skid_valid_d = 1'b1;
      end
    end else if (out_ready) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = !main_valid_q || out_ready;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (accept) begin
      main_d       = in_pl;
      main_valid_d = 1'b1;
    end else if (out_ready) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      flags_q      <= '0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      flags_q      <= flags_d;
    end
  end

  assign out_valid      = main_valid_q;
  assign out_y          = main_q.y;
  assign out_rd         = main_q.rd;
  assign out_wr_en      = main_q.wr_en;
  assign out_mem_rd     = main_q.mem_rd;
  assign out_mem_wr     = main_q.mem_wr;
  assign out_store_data = main_q.store_data;
  assign out_br_target  = main_q.br_target;
  assign out_br_taken   = main_q.br_taken;
  assign nzcv_q         = flags_q;

endmodule
